led_mode_sequencer: RTL
=======================

LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive cycles a changed switch level must persist before it is accepted (minimum 2).
REQ-002 Parameter BLINK_CYCLES, default 12500000, meaning cycles per blink phase in ALT mode (minimum 2).
REQ-003 Parameter LONG_PRESS_CYCLES, default 25000000, meaning debounced hold time that forces OFF; used only with LONG_PRESS_EN.
REQ-004 i_clk  input  1  single clock; all state is on its rising edge.
REQ-005 i_rst  input  1  reset; asynchronous, active-high.
REQ-006 i_switch  input  1  raw push-button level, 1 = pressed; asynchronous to i_clk and bouncy.
REQ-007 o_led_red  output  1  red LED drive, 1 = on.
REQ-008 o_led_blue  output  1  blue LED drive, 1 = on.
REQ-009 o_mode  output  2  current mode: 00 OFF, 01 RED, 10 BLUE, 11 ALT.
REQ-010 o_press  output  1  one-cycle pulse per accepted press-release.

Function
REQ-011 i_switch SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debouncer: the counter SHALL clear whenever the synchronized level equals the debounced level, and increment otherwise; the debounced level SHALL take the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-014 A release event SHALL be a 1->0 transition of the debounced level; o_press SHALL be 1 for exactly the following cycle.
REQ-015 Mode FSM SHALL advance OFF->RED->BLUE->ALT->OFF on each release event, updating o_mode in the same cycle that o_press is high.
REQ-016 Press (0->1 debounced) SHALL NOT change mode; only release advances.
REQ-017 LED decode: OFF both 0; RED red=1 blue=0; BLUE red=0 blue=1; ALT red=~phase, blue=phase.
REQ-018 Outputs SHALL be decoded from registered mode/phase only, with no path from i_switch.
REQ-019 Blink counter SHALL count 0..BLINK_CYCLES-1 in ALT only; at BLINK_CYCLES-1 it SHALL wrap to 0 and toggle phase.
REQ-020 On entering ALT, the blink counter and phase SHALL be 0, so red is lit first for BLINK_CYCLES cycles; outside ALT both SHALL be held at 0.
REQ-021 Counter widths SHALL be $clog2 of their terminal value, with no overflow for any legal parameter.

Reset
REQ-022 Asserting i_rst SHALL immediately clear the synchronizer, the debouncer counter and level, the mode (OFF), the blink counter, the phase, the long-press state and o_press.
REQ-023 Reset mid-debounce or mid-blink SHALL discard progress; after deassertion the outputs are o_mode=00, both LEDs 0, o_press=0.
REQ-024 A switch held through reset deassertion SHALL be debounced as a new press; its later release SHALL advance the mode normally.

Configuration
REQ-025 Macro LED_MODE_SEQUENCER_LONG_PRESS_EN: when defined, a debounced high level held for LONG_PRESS_CYCLES consecutive cycles SHALL force mode OFF on that cycle, and the matching release SHALL produce neither o_press nor a mode advance.
REQ-026 When the macro is undefined, the long-press counter SHALL not exist, hold duration SHALL have no effect, and every release SHALL advance the mode.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=3, LONG_PRESS_CYCLES=20)
REQ-027 Clean press of 10 cycles followed by a release -> one o_press pulse, o_mode 00->01, red=1 blue=0; four releases return to 00.
REQ-028 Release with 1-cycle glitches alternating for 3 cycles, then stable -> no extra o_press; exactly one mode advance after 4 stable cycles.
REQ-029 Enter ALT -> red=1 for 3 cycles, blue=1 for 3 cycles, repeating; the next release gives OFF with both LEDs 0.
REQ-030 Assert i_rst while in BLUE and during a pending debounce -> o_mode=00 and LEDs 0 immediately (asynchronous); no o_press after deassertion.
REQ-031 With the macro defined, in mode 10, hold 25 cycles then release -> o_mode=00 at hold cycle 20, no o_press on release; without the macro -> o_mode 10->11 on release.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// Push-button mode sequencer: synchronizes and debounces a switch, steps OFF/RED/BLUE/ALT on each release.
// Optional feature macro LED_MODE_SEQUENCER_LONG_PRESS_EN: a long debounced hold forces OFF and swallows its release.
module led_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES   = 250000,
   parameter int BLINK_CYCLES      = 12500000,
   parameter int LONG_PRESS_CYCLES = 25000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_switch,
   output logic       o_led_red,
   output logic       o_led_blue,
   output logic [1:0] o_mode,
   output logic       o_press
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BLINK_CYCLES);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : gParamCheck
      $error("led_mode_sequencer: cycle parameters must be at least 2");
   end

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RED  = 2'b01,
      MODE_BLUE = 2'b10,
      MODE_ALT  = 2'b11
   } mode_t;

   logic          sync1_q, sync2_q;
   logic [DW-1:0] debCnt_q, debCnt_d;
   logic          debLvl_q, debLvl_d;
   logic          releaseEvt;
   mode_t         mode_q, mode_d;
   logic          press_q, press_d;
   logic [BW-1:0] blinkCnt_q, blinkCnt_d;
   logic          phase_q, phase_d;

`ifdef LED_MODE_SEQUENCER_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_PRESS_CYCLES);
   localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
   logic [LW-1:0] lpCnt_q, lpCnt_d;
   logic          lpFired_q, lpFired_d;
   logic          fireNow;
`endif

   // Debounce: a differing level must survive DEBOUNCE_CYCLES samples in a row.
   always_comb begin
      debCnt_d   = debCnt_q;
      debLvl_d   = debLvl_q;
      releaseEvt = 1'b0;
      if (sync2_q == debLvl_q) begin
         debCnt_d = '0;
      end else if (debCnt_q == DEB_LAST) begin
         debCnt_d   = '0;
         debLvl_d   = sync2_q;
         releaseEvt = debLvl_q;
      end else begin
         debCnt_d = debCnt_q + 1'b1;
      end
   end

   // Mode stepping on release; a fired long press wins over a coincident release.
   always_comb begin
      mode_d  = mode_q;
      press_d = 1'b0;
`ifdef LED_MODE_SEQUENCER_LONG_PRESS_EN
      lpCnt_d   = lpCnt_q;
      lpFired_d = lpFired_q;
      fireNow   = 1'b0;
      if (!debLvl_q) begin
         lpCnt_d = '0;
      end else if (!lpFired_q) begin
         if (lpCnt_q == LP_LAST) begin
            fireNow   = 1'b1;
            lpFired_d = 1'b1;
            mode_d    = MODE_OFF;
         end else begin
            lpCnt_d = lpCnt_q + 1'b1;
         end
      end
      if (releaseEvt) begin
         lpFired_d = 1'b0;
         lpCnt_d   = '0;
         if (!(lpFired_q || fireNow)) begin
            press_d = 1'b1;
            mode_d  = mode_t'(mode_q + 2'b01);
         end
      end
`else
      if (releaseEvt) begin
         press_d = 1'b1;
         mode_d  = mode_t'(mode_q + 2'b01);
      end
`endif
   end

   // Blink only while staying in ALT, so entry always starts on the red phase.
   always_comb begin
      blinkCnt_d = '0;
      phase_d    = 1'b0;
      if (mode_q == MODE_ALT && mode_d == MODE_ALT) begin
         if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d = '0;
            phase_d    = ~phase_q;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
            phase_d    = phase_q;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         debCnt_q   <= '0;
         debLvl_q   <= 1'b0;
         mode_q     <= MODE_OFF;
         press_q    <= 1'b0;
         blinkCnt_q <= '0;
         phase_q    <= 1'b0;
`ifdef LED_MODE_SEQUENCER_LONG_PRESS_EN
         lpCnt_q    <= '0;
         lpFired_q  <= 1'b0;
`endif
      end else begin
         sync1_q    <= i_switch;
         sync2_q    <= sync1_q;
         debCnt_q   <= debCnt_d;
         debLvl_q   <= debLvl_d;
         mode_q     <= mode_d;
         press_q    <= press_d;
         blinkCnt_q <= blinkCnt_d;
         phase_q    <= phase_d;
`ifdef LED_MODE_SEQUENCER_LONG_PRESS_EN
         lpCnt_q    <= lpCnt_d;
         lpFired_q  <= lpFired_d;
`endif
      end
   end

   assign o_mode     = mode_q;
   assign o_press    = press_q;
   assign o_led_red  = (mode_q == MODE_RED)  || (mode_q == MODE_ALT && !phase_q);
   assign o_led_blue = (mode_q == MODE_BLUE) || (mode_q == MODE_ALT &&  phase_q);

endmodule
